fp_addsub_norm_round: RTL and testbench

- Stage directly downstream of the FP adder sign/swap stage. It consumes the ordered, aligned 28-bit mantissas (larger first), the effective-subtract flag and the result sign.
- It adds or subtracts the mantissas, normalizes the result (leading-zero count plus shift), rounds to nearest-even and packs an IEEE-754 single.
- 3-stage pipeline with valid/ready flow control. Feeds the FPU result register.

---
 rtl/fp_addsub_norm_round.sv | 162 ++++++++++++++++
 tb/tb_fp_addsub_norm_round.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_norm_round.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_norm_round
// Function : FP add/sub mantissa stage: add/sub, normalize, RNE round, pack.
// Revision : 1.0
// ============================================================================
module fp_addsub_norm_round #(
  parameter int EW = 8,
  parameter int FW = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [FW+4:0]     Aa,
  input  logic [FW+4:0]     Bb,
  input  logic              AS,
  input  logic              SO,
  input  logic [EW-1:0]     EXP,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [EW+FW:0]    RES,
  output logic              OF,
  output logic              UF,
  output logic              ZR
);

  localparam int MW  = FW + 5;
  localparam int LZW = $clog2(MW);
  localparam logic signed [EW+1:0] c_E_ONE = {{(EW+1){1'b0}}, 1'b1};
  localparam logic [EW+1:0]        c_EMAX  = {2'b00, {EW{1'b1}}};

  logic w_adv;

  logic                  r_v1, r_v2, r_v3;
  logic [MW-1:0]         r1_s;
  logic                  r1_so, r1_as;
  logic signed [EW+1:0]  r1_e;

  logic [MW-2:0]         r2_m;
  logic signed [EW+1:0]  r2_e;
  logic                  r2_sign, r2_zr, r2_uf;

  logic [EW+FW:0]        r_res;
  logic                  r_of, r_uf, r_zr;

  assign w_adv     = !r_v3 || OUT_READY;
  assign IN_READY  = w_adv;
  assign OUT_VALID = r_v3;
  assign RES       = r_res;
  assign OF        = r_of;
  assign UF        = r_uf;
  assign ZR        = r_zr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= IN_VALID;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  // Stage 1: Aa >= Bb is guaranteed upstream, so subtraction never wraps.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r1_s  <= AS ? (Aa - Bb) : (Aa + Bb);
      r1_so <= SO;
      r1_as <= AS;
      r1_e  <= $signed({2'b00, EXP});
    end
  end

  // Stage 2: leading-zero count over the bits below the carry headroom.
  logic [LZW-1:0]       w_lz;
  logic                 w_found;
  logic [MW-2:0]        w_m;
  logic signed [EW+1:0] w_e2;
  logic                 w_sign2, w_zr2, w_uf2;

  always_comb begin
    w_lz    = '0;
    w_found = 1'b0;
    for (int i = MW - 2; i >= 0; i--) begin
      if (!w_found && r1_s[i]) begin
        w_found = 1'b1;
        w_lz    = LZW'(MW - 2 - i);
      end
    end
  end

  always_comb begin
    w_m     = r1_s[MW-2:0];
    w_e2    = r1_e;
    w_sign2 = r1_so;
    w_zr2   = 1'b0;
    w_uf2   = 1'b0;
    if (r1_s == '0) begin
      w_zr2   = 1'b1;
      w_sign2 = r1_as ? 1'b0 : r1_so;
    end else if (r1_s[MW-1]) begin
      w_m  = {r1_s[MW-1:2], r1_s[1] | r1_s[0]};
      w_e2 = r1_e + c_E_ONE;
    end else begin
      w_m  = r1_s[MW-2:0] << w_lz;
      w_e2 = r1_e - $signed({{(EW+2-LZW){1'b0}}, w_lz});
    end
    if (!w_zr2 && (w_e2[EW+1] || (w_e2 == '0))) begin
      w_uf2 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r2_m    <= w_m;
      r2_e    <= w_e2;
      r2_sign <= w_sign2;
      r2_zr   <= w_zr2;
      r2_uf   <= w_uf2;
    end
  end

  // Stage 3: round to nearest even on guard/round/sticky, then pack.
  logic                 w_up, w_carry, w_of;
  logic [FW-1:0]        w_frac;
  logic signed [EW+1:0] w_e3;
  logic [EW+FW:0]       w_res;

  always_comb begin
    w_up    = r2_m[2] && (r2_m[1] || r2_m[0] || r2_m[3]);
    w_carry = w_up && (&r2_m[MW-2:3]);
    w_frac  = r2_m[MW-3:3] + {{(FW-1){1'b0}}, w_up};
    w_e3    = w_carry ? (r2_e + c_E_ONE) : r2_e;
    w_of    = !r2_zr && !r2_uf && ($unsigned(w_e3) >= c_EMAX);
    if (r2_zr || r2_uf) begin
      w_res = {r2_sign, {(EW+FW){1'b0}}};
    end else if (w_of) begin
      w_res = {r2_sign, {EW{1'b1}}, {FW{1'b0}}};
    end else begin
      w_res = {r2_sign, w_e3[EW-1:0], w_frac};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= '0;
      r_of  <= 1'b0;
      r_uf  <= 1'b0;
      r_zr  <= 1'b0;
    end else if (w_adv) begin
      r_res <= w_res;
      r_of  <= w_of;
      r_uf  <= r2_uf;
      r_zr  <= r2_zr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_norm_round.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_norm_round
// Function : Randomized self-checking bench with a value-level RNE model.
// Revision : 1.0
// ============================================================================
module tb_fp_addsub_norm_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [27:0] Aa = '0;
  logic [27:0] Bb = '0;
  logic        AS = 1'b0;
  logic        SO = 1'b0;
  logic [7:0]  EXP = 8'd1;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] RES;
  logic        OF, UF, ZR;

  fp_addsub_norm_round #(.EW(8), .FW(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .Aa(Aa), .Bb(Bb), .AS(AS), .SO(SO), .EXP(EXP),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RES(RES), .OF(OF), .UF(UF), .ZR(ZR)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  fl;   // {OF, UF, ZR}
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  int          stall_left = 0;
  bit          rnd_rdy = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [2:0]  prev_fl;
  bit          bp_mode = 1'b0;
  int          bp_acc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Exact-value model: locate the MSB, keep 24 significant bits, round half-to-even.
  function automatic exp_t model(input logic [27:0] a, input logic [27:0] b,
                                 input logic as_i, input logic so_i, input logic [7:0] ex);
    exp_t   r;
    longint s, keep, rem, half;
    int     p, e, sh;
    s = as_i ? (longint'(a) - longint'(b)) : (longint'(a) + longint'(b));
    if (s == 0) begin
      r.res = {(as_i ? 1'b0 : so_i), 31'b0};
      r.fl  = 3'b001;
      return r;
    end
    p = 0;
    for (int i = 0; i < 28; i++) if (s[i]) p = i;
    e = int'(ex) + p - 26;
    if (e <= 0) begin
      r.res = {so_i, 31'b0};
      r.fl  = 3'b010;
      return r;
    end
    if (p > 23) begin
      sh   = p - 23;
      keep = s >> sh;
      rem  = s & ((64'sd1 << sh) - 1);
      half = 64'sd1 << (sh - 1);
      if ((rem > half) || ((rem == half) && keep[0])) keep = keep + 1;
    end else begin
      keep = s << (23 - p);
    end
    if (keep == (64'sd1 << 24)) begin
      keep = keep >> 1;
      e++;
    end
    if (e >= 255) begin
      r.res = {so_i, 8'hFF, 23'b0};
      r.fl  = 3'b100;
    end else begin
      r.res = {so_i, e[7:0], keep[22:0]};
      r.fl  = 3'b000;
    end
    return r;
  endfunction

  // One clock: choose OUT_READY, check what leaves / holds, note acceptance.
  task automatic step(output bit acc);
    exp_t e;
    OUT_READY = (stall_left > 0) ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    #1;
    if (prev_stall) begin
      check_eq("hold_valid", OUT_VALID, 1);
      check_eq("hold_res", RES, prev_res);
      check_eq("hold_flags", {OF, UF, ZR}, prev_fl);
    end
    prev_stall = OUT_VALID && !OUT_READY;
    prev_res   = RES;
    prev_fl    = {OF, UF, ZR};
    acc = IN_VALID && IN_READY;
    if (OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_out", OUT_VALID, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("res", RES, e.res);
        check_eq("flags", {OF, UF, ZR}, e.fl);
      end
    end
    if (acc) exp_q.push_back(cur);
    if (bp_mode) begin
      if (stall_left > 0 && acc) bp_acc++;
      if (stall_left == 1) begin
        check_eq("bp_accepted", bp_acc, 3);
        check_eq("bp_in_ready", IN_READY, 0);
        bp_mode = 1'b0;
      end
    end
    if (stall_left > 0) stall_left--;
    @(negedge clk);
  endtask

  task automatic send(input logic [27:0] a, input logic [27:0] b, input logic as_i,
                      input logic so_i, input logic [7:0] ex, input exp_t want);
    bit acc;
    acc = 1'b0;
    Aa = a; Bb = b; AS = as_i; SO = so_i; EXP = ex;
    cur = want;
    IN_VALID = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) step(acc);
    if (!acc) check_eq("accept_timeout", acc, 1);
    IN_VALID = 1'b0;
  endtask

  task automatic send_m(input logic [27:0] a, input logic [27:0] b, input logic as_i,
                        input logic so_i, input logic [7:0] ex);
    send(a, b, as_i, so_i, ex, model(a, b, as_i, so_i, ex));
  endtask

  task automatic idle(input int n);
    bit acc;
    IN_VALID = 1'b0;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic drain();
    bit acc;
    IN_VALID = 1'b0;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step(acc);
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] a, b, t;
    logic [7:0]  ex;
    #12;
    check_eq("rst_valid", OUT_VALID, 0);
    check_eq("rst_res", RES, 0);
    check_eq("rst_flags", {OF, UF, ZR}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    send(28'h4000000, 28'h4000000, 0, 0, 8'd127, {32'h40000000, 3'b000});
    send(28'h4000000, 28'h4000000, 1, 1, 8'd127, {32'h00000000, 3'b001});
    send(28'h4000000, 28'h0000008, 1, 0, 8'd127, {32'h3F7FFFFE, 3'b000});
    send(28'h4000004, 28'h0000000, 0, 0, 8'd127, {32'h3F800000, 3'b000});
    send(28'h400000C, 28'h0000000, 0, 0, 8'd127, {32'h3F800002, 3'b000});
    send(28'h7FFFFFC, 28'h0000000, 0, 0, 8'd127, {32'h40000000, 3'b000});
    send(28'h7FFFFF8, 28'h7FFFFF8, 0, 0, 8'd254, {32'h7F800000, 3'b100});
    send(28'h4000000, 28'h3FFFFF8, 1, 0, 8'd5,   {32'h00000000, 3'b010});
    send(28'h0000000, 28'h0000000, 0, 1, 8'd9,   {32'h80000000, 3'b001});
    send(28'h7FFFFFC, 28'h0000000, 0, 1, 8'd254, {32'hFF800000, 3'b100});
    drain();

    // Backpressure: five back-to-back beats against six stalled cycles.
    bp_mode = 1'b1; bp_acc = 0; stall_left = 6;
    for (int k = 0; k < 5; k++)
      send_m(28'h4000000 + 28'(k * 1000), 28'(k * 37), k[0], k[1], 8'(100 + k));
    drain();

    // Reset mid-flight.
    send_m(28'h4123456, 28'h0012345, 0, 0, 8'd80);
    send_m(28'h4654321, 28'h0100000, 1, 1, 8'd90);
    idle(1);
    check_eq("pre_rst_valid", OUT_VALID, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", OUT_VALID, 0);
    check_eq("mid_rst_res", RES, 0);
    check_eq("mid_rst_flags", {OF, UF, ZR}, 0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);

    // Randomized traffic with random consumer backpressure.
    rnd_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      a = {2'b01, 26'($urandom)};
      if ($urandom_range(0, 7) == 0) b = a - 28'($urandom_range(0, 64));
      else b = {2'b01, 26'($urandom)} >> $urandom_range(0, 30);
      if (b > a) begin t = a; a = b; b = t; end
      case ($urandom_range(0, 3))
        0:       ex = 8'($urandom_range(1, 30));
        1:       ex = 8'($urandom_range(225, 254));
        default: ex = 8'($urandom_range(1, 254));
      endcase
      send_m(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ex);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    rnd_rdy = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
